// File: rtl/if_fetch_unit.sv
// Instruction-fetch sequencer: drives the external PC register (pc_d/pc_ce),
// issues single-outstanding imem reads and hands fetched words to decode.
//
// state  | meaning
// BOOT   | load RESET_PC into the PC register
// ISSUE  | capture pc_q as the read address
// WAIT   | request outstanding, waiting for ack
// HOLD   | instruction presented to decode, waiting for inst_ready
// DRAIN  | redirected while a read was in flight; discard its data
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        pc_ce,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    pc_ce        = 1'b0;
    pc_d         = '0;
    imem_req     = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        pc_ce   = 1'b1;
        pc_d    = RESET_PC;
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        addr_d = pc_q;
        if (redirect) begin
          // address captured this cycle is stale; re-captured next cycle
          pc_ce = 1'b1;
          pc_d  = redirect_pc;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_ce   = 1'b1;
          pc_d    = redirect_pc;
          state_d = imem_ack ? S_ISSUE : S_DRAIN;
        end else if (imem_ack) begin
          inst_d       = imem_rdata;
          inst_pc_d    = addr_q;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        // a redirect here belongs to an older instruction, so a
        // simultaneous handshake still counts as a transfer
        if (inst_ready) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (redirect) begin
          pc_ce        = 1'b1;
          pc_d         = redirect_pc;
          inst_valid_d = 1'b0;
          state_d      = S_ISSUE;
        end else if (inst_ready) begin
          pc_ce        = 1'b1;
          pc_d         = pc_q + PC_STEP;
          inst_valid_d = 1'b0;
          state_d      = S_ISSUE;
        end
      end

      S_DRAIN: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_ce = 1'b1;
          pc_d  = redirect_pc;
        end
        if (imem_ack) state_d = S_ISSUE;
      end

      default: state_d = S_BOOT;
    endcase

    if (rst) begin
      pc_ce    = 1'b0;
      pc_d     = '0;
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      addr_q       <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign imem_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: external PC register and a simple
// latency-programmable memory, with a scoreboard of expected transfers.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] MAGIC  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_reg = '0;
  logic [31:0] pc_d;
  logic        pc_ce;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] fetch_cnt;

  logic [31:0] ack_lat;
  logic [31:0] req_cycles;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } xfer_t;

  xfer_t sb[$];
  int    xfer_cyc[$];
  int    checks  = 0;
  int    errors  = 0;
  int    cyc_n   = 0;
  int    exp_cnt = 0;

  if_fetch_unit #(
    .RESET_PC (RST_PC),
    .PC_STEP  (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_q        (pc_reg),
    .pc_d        (pc_d),
    .pc_ce       (pc_ce),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_ce) pc_reg <= pc_d;

  // memory acks on the ack_lat-th request cycle; data varies per cycle
  always @(posedge clk or posedge rst) begin
    if (rst) req_cycles <= '0;
    else if (!imem_req || imem_ack) req_cycles <= '0;
    else req_cycles <= req_cycles + 32'd1;
  end
  assign imem_ack   = imem_req && (req_cycles == ack_lat - 32'd1);
  assign imem_rdata = imem_addr ^ MAGIC ^ req_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    sb.push_back({pc, ins});
    exp_cnt++;
  endtask

  // one clock: monitor handshakes at negedge, return 1 time unit after posedge
  task automatic cyc();
    xfer_t e;
    @(negedge clk);
    cyc_n++;
    if (inst_valid && inst_ready) begin
      xfer_cyc.push_back(cyc_n);
      if (sb.size() == 0) begin
        check("xfer_expected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("xfer_pc", inst_pc, e.pc);
        check("xfer_inst", inst, e.ins);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !inst_valid; i++) cyc();
    check(tag, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) cyc();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int boot_c;
    int req_n;
    int drain_n;

    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b1;
    ack_lat     = 32'd1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("rst_pc_ce", 32'(pc_ce), 32'd0);
    check("rst_pc_d", pc_d, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);

    // boot and zero-wait streaming
    rst    = 1'b0;
    boot_c = cyc_n + 1;
    #1;
    check("boot_pc_ce", 32'(pc_ce), 32'd1);
    check("boot_pc_d", pc_d, RST_PC);
    check("boot_req", 32'(imem_req), 32'd0);
    push(32'h100, 32'h100 ^ MAGIC);
    push(32'h104, 32'h104 ^ MAGIC);
    push(32'h108, 32'h108 ^ MAGIC);
    wait_empty("boot_xfers");
    check("boot_cnt", fetch_cnt, 32'd3);
    if (xfer_cyc.size() >= 3) begin
      check("boot_latency", 32'(xfer_cyc[0] - boot_c), 32'd3);
      check("boot_gap1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
      check("boot_gap2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd3);
    end else begin
      check("boot_xfer_count", 32'(xfer_cyc.size()), 32'd3);
    end

    // backpressure in HOLD
    inst_ready = 1'b0;
    push(32'h10C, 32'h10C ^ MAGIC);
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(inst_valid), 32'd1);
      check("bp_hold_inst", inst, 32'h10C ^ MAGIC);
      check("bp_hold_pc", inst_pc, 32'h10C);
      check("bp_hold_ce", 32'(pc_ce), 32'd0);
      check("bp_hold_req", 32'(imem_req), 32'd0);
      cyc();
    end
    inst_ready = 1'b1;
    #1;
    check("bp_ce", 32'(pc_ce), 32'd1);
    check("bp_pc_d", pc_d, 32'h110);
    cyc();
    check("bp_cnt", fetch_cnt, 32'd4);
    check("bp_valid_drop", 32'(inst_valid), 32'd0);

    // memory wait states
    ack_lat = 32'd4;
    push(32'h110, 32'h110 ^ MAGIC ^ 32'd3);
    req_n = 0;
    for (int i = 0; i < 12 && !inst_valid; i++) begin
      if (imem_req) begin
        req_n++;
        check("ws_addr", imem_addr, 32'h110);
      end
      cyc();
    end
    check("ws_req_cycles", 32'(req_n), 32'd4);
    wait_empty("ws_xfer");

    // redirect in WAIT before ack
    cyc();
    check("rw_req", 32'(imem_req), 32'd1);
    check("rw_addr", imem_addr, 32'h114);
    redirect    = 1'b1;
    redirect_pc = 32'h2000;
    #1;
    check("rw_ce", 32'(pc_ce), 32'd1);
    check("rw_pc_d", pc_d, 32'h2000);
    cyc();
    redirect    = 1'b0;
    redirect_pc = '0;
    drain_n     = 0;
    for (int i = 0; i < 10 && imem_req; i++) begin
      check("rw_drain_addr", imem_addr, 32'h114);
      check("rw_no_valid", 32'(inst_valid), 32'd0);
      drain_n++;
      cyc();
    end
    check("rw_drain_cycles", 32'(drain_n), 32'd3);
    check("rw_issue_no_valid", 32'(inst_valid), 32'd0);
    push(32'h2000, 32'h2000 ^ MAGIC ^ 32'd3);
    cyc();
    check("rw_new_req", 32'(imem_req), 32'd1);
    check("rw_new_addr", imem_addr, 32'h2000);
    wait_empty("rw_xfer");

    // redirect in HOLD together with inst_ready
    ack_lat    = 32'd1;
    inst_ready = 1'b0;
    push(32'h2004, 32'h2004 ^ MAGIC);
    wait_valid("rh_valid");
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    #1;
    check("rh_ce", 32'(pc_ce), 32'd1);
    check("rh_pc_d", pc_d, 32'h40);
    cyc();
    redirect = 1'b0;
    check("rh_cnt", fetch_cnt, 32'(exp_cnt));
    push(32'h40, 32'h40 ^ MAGIC);
    wait_empty("rh_xfer");

    // redirect in ISSUE, then wrap of the sequential increment
    check("is_req", 32'(imem_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    check("is_ce", 32'(pc_ce), 32'd1);
    check("is_pc_d", pc_d, 32'hFFFF_FFFC);
    cyc();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    push(32'hFFFF_FFFC, 32'hFFFF_FFFC ^ MAGIC);
    wait_valid("wrap_valid");
    inst_ready = 1'b1;
    #1;
    check("wrap_ce", 32'(pc_ce), 32'd1);
    check("wrap_pc_d", pc_d, 32'h0);
    cyc();
    check("wrap_cnt", fetch_cnt, 32'(exp_cnt));

    // reset mid-WAIT
    ack_lat = 32'd4;
    cyc();
    check("rs_req_before", 32'(imem_req), 32'd1);
    check("rs_addr_before", imem_addr, 32'h0);
    rst = 1'b1;
    #1;
    check("rs_req", 32'(imem_req), 32'd0);
    check("rs_valid", 32'(inst_valid), 32'd0);
    check("rs_cnt", fetch_cnt, 32'd0);
    check("rs_ce", 32'(pc_ce), 32'd0);
    sb.delete();
    exp_cnt = 0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("rb_ce", 32'(pc_ce), 32'd1);
    check("rb_pc_d", pc_d, RST_PC);
    ack_lat = 32'd1;
    push(32'h100, 32'h100 ^ MAGIC);
    wait_empty("rb_xfer");
    check("rb_cnt", fetch_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch sequencer that sits directly upstream of the 32-bit PC register, and also consumes that register's output.
- Computes the next PC and the PC register's clock enable from the register's current value.
- Issues single-outstanding req/ack reads to instruction memory and presents each fetched word to decode over a valid/ready handshake.
- Accepts branch/jump redirects from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded into the PC register in the first cycle after reset release
PC_STEP, 4, byte increment between sequential instructions

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
pc_q  in  32  current PC from PC register Q
pc_d  out  32  next PC to PC register D
pc_ce  out  1  PC register clock enable (single-cycle pulse)
imem_req  out  1  instruction read request
imem_addr  out  32  read address, stable while imem_req high
imem_ack  in  1  read done; imem_rdata valid this cycle
imem_rdata  in  32  read data
redirect  in  1  redirect request, single-cycle
redirect_pc  in  32  redirect target
inst_valid  out  1  inst/inst_pc valid to decode
inst_ready  in  1  decode accepts
inst  out  32  fetched instruction
inst_pc  out  32  address of inst
fetch_cnt  out  32  count of instructions transferred to decode

Behaviour:
- Reset (async, rst high): state=BOOT; inst_valid=0; inst=0; inst_pc=0; imem_addr register=0; fetch_cnt=0.
- While rst is high, pc_ce=0, pc_d=0 and imem_req=0.
- pc_ce, pc_d and imem_req are combinational from state and inputs. All other outputs are registered.
- PC register timing: a pc_ce pulse in cycle T makes pc_q show pc_d from cycle T+1.
- States:
  - BOOT: pc_ce=1, pc_d=RESET_PC; next ISSUE. redirect ignored.
  - ISSUE: imem_req=0; imem_addr<=pc_q; next WAIT.
    - If redirect: pc_ce=1, pc_d=redirect_pc, stay ISSUE (captured address is stale and re-captured next cycle).
  - WAIT: imem_req=1, imem_addr held.
    - ack & !redirect: inst<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1; next HOLD.
    - ack & redirect: data discarded; pc_ce=1, pc_d=redirect_pc; next ISSUE.
    - !ack & redirect: pc_ce=1, pc_d=redirect_pc; next DRAIN.
  - HOLD: inst_valid=1, no memory request.
    - inst_ready & !redirect: pc_ce=1, pc_d=pc_q+PC_STEP; inst_valid<=0; next ISSUE.
    - redirect: pc_ce=1, pc_d=redirect_pc; inst_valid<=0; next ISSUE. If inst_ready is also high, the transfer still counts (redirect belongs to an older instruction).
  - DRAIN: imem_req=1, imem_addr held; wait for ack, then discard data and go to ISSUE.
    - redirect in DRAIN: pc_ce=1, pc_d=redirect_pc, stay DRAIN (latest redirect wins).
- Fetch latency: from entering ISSUE, the earliest inst_valid is 2 cycles (zero-wait memory: ack in first WAIT cycle).
- Steady-state throughput with zero-wait memory and inst_ready=1: one instruction per 3 cycles.
- Arithmetic: pc_q+PC_STEP is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- fetch_cnt increments on each inst_valid&inst_ready and wraps modulo 2^32.
- inst and inst_pc hold while inst_valid is high and the transfer has not occurred.
- imem_req never drops before ack; imem_addr never changes while imem_req is high.
- At most one request is outstanding.
- Reset mid-transaction: all state cleared immediately and req drops. Memory must tolerate an abandoned request.
- imem_ack outside WAIT/DRAIN is ignored.

Test Plan:
- Boot, RESET_PC=32'h100, zero-wait memory returning addr^32'hA5A5_0000, inst_ready=1:
  - pc_ce high in first post-reset cycle with pc_d=32'h100.
  - Transfers at inst_pc 32'h100, 32'h104, 32'h108, one per 3 cycles.
  - fetch_cnt=3 after the third.
- Backpressure: inst_ready=0 for 5 cycles in HOLD:
  - inst_valid stays 1, inst and inst_pc stable, pc_ce=0, imem_req=0.
  - On inst_ready=1, exactly one transfer occurs and pc_d=inst_pc+4.
- Memory wait states, ack delayed 4 cycles:
  - imem_req high for 4 cycles, imem_addr constant.
  - inst equals the data sampled on the ack cycle.
- Redirect in WAIT before ack to 32'h2000, ack 3 cycles later:
  - pc_ce pulse with pc_d=32'h2000, state DRAIN.
  - Stale data never reaches inst_valid.
  - Next request address is 32'h2000.
- Redirect in HOLD with inst_ready=1 simultaneously, target 32'h40:
  - Transfer counted (fetch_cnt+1), pc_d=32'h40.
  - Next inst_pc=32'h40.
- Wrap and reset: pc_q=32'hFFFF_FFFC delivered and accepted gives pc_d=0. rst pulse asserted mid-WAIT gives:
  - imem_req=0 and inst_valid=0 immediately.
  - fetch_cnt=0.
  - BOOT sequence repeats.
